// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the camera I2C configuration sequencer.
package i2c_cfg_pkg;

    localparam int         TIMER_W    = 32;
    localparam logic [7:0] DELAY_MARK = 8'hFF;

    typedef enum logic [3:0] {
        PWR_WAIT,
        FETCH,
        LOAD,
        REQ,
        WAIT_ACK,
        NEXT,
        DELAY,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Table-ROM, I2C-sender and status signals of the configuration sequencer.
interface i2c_cfg_sequencer_if #(
    parameter int IDX_W = 8
);
    logic             cfg_start;
    logic [IDX_W-1:0] lut_addr;
    logic [31:0]      lut_data;
    logic [31:0]      cfg_data;
    logic             i2c_req;
    logic             i2c_ack;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        input  cfg_start, lut_data, i2c_ack,
        output lut_addr, cfg_data, i2c_req, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        output cfg_start, lut_data, i2c_ack,
        input  lut_addr, cfg_data, i2c_req, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/cfg_timer.sv
// Up-counter with synchronous clear and a terminal-count match; shared by the
// power-up wait, the ack timeout and the delay command.
module cfg_timer
    import i2c_cfg_pkg::*;
(
    input  logic               clk_100,
    input  logic               rst_100,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] term_i,
    output logic               match_o
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign match_o = (count_q == term_i);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the camera register table and hands each word to the I2C write engine.
// Optional delay commands (0xFF-prefixed words) are enabled by CFG_DELAY_EN.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int CFG_NUM       = 64,
    parameter int IDX_W         = 8,
    parameter int PWR_UP_CYCLES = 2000000,
    parameter int ACK_TIMEOUT   = 1000000,
    parameter int DELAY_UNIT    = 100000
) (
    input  logic                  clk_100,
    input  logic                  rst_100,
    i2c_cfg_sequencer_if.master   bus
);

    localparam logic [TIMER_W-1:0] PWR_TERM = TIMER_W'(PWR_UP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ACK_TERM = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CFG_NUM - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   lut_addr_q;
    logic [31:0]        cfg_data_q;
    logic               req_q, busy_q, done_q, err_q;

    logic               tmr_clr, tmr_en, tmr_match;
    logic [TIMER_W-1:0] tmr_term;

`ifdef CFG_DELAY_EN
    logic [TIMER_W-1:0] delay_cycles, delay_term;

    // A zero-length delay still spends one cycle in DELAY.
    assign delay_cycles = TIMER_W'(cfg_data_q[15:0]) * TIMER_W'(DELAY_UNIT);
    assign delay_term   = (delay_cycles == '0) ? '0 : delay_cycles - 1'b1;
`endif

    cfg_timer u_timer (
        .clk_100 (clk_100),
        .rst_100 (rst_100),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .term_i  (tmr_term),
        .match_o (tmr_match)
    );

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = PWR_TERM;
        case (state_q)
            PWR_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_match) state_d = FETCH;
            end
            FETCH: begin
                tmr_clr = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                tmr_clr = 1'b1;
`ifdef CFG_DELAY_EN
                state_d = (bus.lut_data[31:24] == DELAY_MARK) ? DELAY : REQ;
`else
                state_d = REQ;
`endif
            end
            // The timeout window opens on the request cycle itself.
            REQ: begin
                tmr_en   = 1'b1;
                tmr_term = ACK_TERM;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                tmr_en   = 1'b1;
                tmr_term = ACK_TERM;
                if (bus.i2c_ack)    state_d = NEXT;
                else if (tmr_match) state_d = ERR;
            end
            NEXT: begin
                tmr_clr = 1'b1;
                if (index_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = FETCH;
                end
            end
`ifdef CFG_DELAY_EN
            DELAY: begin
                tmr_en   = 1'b1;
                tmr_term = delay_term;
                if (tmr_match) state_d = NEXT;
            end
`endif
            DONE, ERR: begin
                tmr_clr = 1'b1;
                if (bus.cfg_start) begin
                    index_d = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // Outputs are registered from the next state so they align with the state.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            state_q    <= PWR_WAIT;
            index_q    <= '0;
            lut_addr_q <= '0;
            cfg_data_q <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (state_d == FETCH) lut_addr_q <= index_d;
            if (state_q == LOAD)  cfg_data_q <= bus.lut_data;
            req_q  <= (state_d == REQ);
            busy_q <= !((state_d == DONE) || (state_d == ERR));
            done_q <= (state_d == DONE);
            err_q  <= (state_d == ERR);
        end
    end

    assign bus.lut_addr = lut_addr_q;
    assign bus.cfg_data = cfg_data_q;
    assign bus.i2c_req  = req_q;
    assign bus.cfg_busy = busy_q;
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: expected requests are queued by the
// stimulus and checked by a monitor when i2c_req is seen.
module tb_i2c_cfg_sequencer;

    localparam int P       = 100;
    localparam int T       = 200;
    localparam int U       = 10;
    localparam int N       = 3;
    localparam int IW      = 8;
    localparam int ACK_LAT = 50;

    logic clk_100 = 1'b0;
    logic rst_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    i2c_cfg_sequencer_if #(.IDX_W(IW)) bus ();

    i2c_cfg_sequencer #(
        .CFG_NUM       (N),
        .IDX_W         (IW),
        .PWR_UP_CYCLES (P),
        .ACK_TIMEOUT   (T),
        .DELAY_UNIT    (U)
    ) dut (
        .clk_100 (clk_100),
        .rst_100 (rst_100),
        .bus     (bus)
    );

    // Synchronous ROM with one cycle of latency.
    logic [31:0] rom [0:255];
    logic [31:0] rom_q;
    always @(posedge clk_100) rom_q <= rom[bus.lut_addr];
    assign bus.lut_data = rom_q;

    logic ack_model = 1'b0;
    logic ack_spur  = 1'b0;
    logic ack_on    = 1'b0;
    int   cd        = 0;
    assign bus.i2c_ack = ack_model | ack_spur;

    int cyc;
    always @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int checks  = 0;
    int errors  = 0;
    int req_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Ack model: one-cycle ack ACK_LAT cycles after each request.
    always @(negedge clk_100) begin
        ack_model = 1'b0;
        if (!rst_100) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) ack_model = 1'b1;
            end
            if (bus.i2c_req === 1'b1 && ack_on) cd = ACK_LAT;
        end
    end

    // Monitor: every request must match the head of the expected queue.
    always @(negedge clk_100) begin
        exp_t e;
        if (rst_100 && bus.i2c_req === 1'b1) begin
            req_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got data %0h expected none (cyc %0d)", bus.cfg_data, cyc);
            end else begin
                e = exp_q.pop_front();
                $display("req cyc %0d data %08h (expected cyc %0d data %08h)", cyc, bus.cfg_data, e.at, e.data);
                chk("req_data", bus.cfg_data, e.data);
                chk("req_cycle", cyc, e.at);
            end
        end
    end

    task automatic push(input int at, input logic [31:0] data);
        exp_t e;
        e.at   = at;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick_to(input int t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk_100);
            guard++;
        end
        if (cyc != t) chk("tick_to", cyc, t);
    endtask

    task automatic do_reset();
        exp_q.delete();
        ack_spur      = 1'b0;
        bus.cfg_start = 1'b0;
        @(negedge clk_100);
        rst_100 = 1'b0;
        repeat (2) @(negedge clk_100);
        chk("rst_busy", bus.cfg_busy, 0);
        chk("rst_done", bus.cfg_done, 0);
        chk("rst_err",  bus.cfg_err, 0);
        chk("rst_req",  bus.i2c_req, 0);
        chk("rst_addr", bus.lut_addr, 0);
        chk("rst_data", bus.cfg_data, 0);
        rst_100 = 1'b1;
        req_cnt = 0;
        @(negedge clk_100);
        chk("busy_after_rst", bus.cfg_busy, 1);
    endtask

    task automatic pulse_start();
        bus.cfg_start = 1'b1;
        @(negedge clk_100);
        bus.cfg_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] tbl_a [0:2];
    logic [31:0] tbl_b [0:2];
    int s, cnt0;

    initial begin
        tbl_a[0] = 32'h7830_0812; tbl_a[1] = 32'h7830_0882; tbl_a[2] = 32'h7831_0301;
        tbl_b[0] = 32'h7830_0812; tbl_b[1] = 32'hFF00_0003; tbl_b[2] = 32'h7830_0882;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int i = 0; i < 3; i++) rom[i] = tbl_a[i];
        bus.cfg_start = 1'b0;

        // Case 1: normal run; requests at 102, 102+54, 102+108; done two cycles after last ack.
        ack_on = 1'b1;
        do_reset();
        push(102, tbl_a[0]); push(156, tbl_a[1]); push(210, tbl_a[2]);
        tick_to(261); chk("c1_done_early", bus.cfg_done, 0);
        tick_to(262); chk("c1_done", bus.cfg_done, 1); chk("c1_busy", bus.cfg_busy, 0);
        chk("c1_req_cnt", req_cnt, 3); chk("c1_exp_left", exp_q.size(), 0);

        // Case 2: silent sender; timeout T cycles after the request.
        ack_on = 1'b0;
        do_reset();
        push(102, tbl_a[0]);
        tick_to(102 + T - 1); chk("c2_err_early", bus.cfg_err, 0);
        tick_to(102 + T);     chk("c2_err", bus.cfg_err, 1); chk("c2_busy", bus.cfg_busy, 0);
        tick_to(102 + T + 1000);
        chk("c2_req_cnt", req_cnt, 1); chk("c2_err_sticky", bus.cfg_err, 1);

        // Case 3: restart from ERR without a power-up wait.
        ack_on = 1'b1;
        s = cyc;
        push(s + 3, tbl_a[0]); push(s + 57, tbl_a[1]); push(s + 111, tbl_a[2]);
        pulse_start();
        chk("c3_err_clr", bus.cfg_err, 0); chk("c3_addr", bus.lut_addr, 0); chk("c3_busy", bus.cfg_busy, 1);
        tick_to(s + 163); chk("c3_done", bus.cfg_done, 1); chk("c3_exp_left", exp_q.size(), 0);

        // Case 4: start during WAIT_ACK and ack during FETCH are both ignored.
        tick_to(s + 200);
        s = cyc; cnt0 = req_cnt;
        push(s + 3, tbl_a[0]); push(s + 57, tbl_a[1]); push(s + 111, tbl_a[2]);
        pulse_start();
        chk("c4_done_clr", bus.cfg_done, 0); chk("c4_addr", bus.lut_addr, 0);
        tick_to(s + 20); pulse_start();
        tick_to(s + 55); ack_spur = 1'b1; @(negedge clk_100); ack_spur = 1'b0;
        tick_to(s + 162); chk("c4_done_early", bus.cfg_done, 0);
        tick_to(s + 163); chk("c4_done", bus.cfg_done, 1);
        chk("c4_req_cnt", req_cnt - cnt0, 3); chk("c4_exp_left", exp_q.size(), 0);

        // Case 5: asynchronous reset in WAIT_ACK of the second entry.
        tick_to(s + 200);
        s = cyc;
        push(s + 3, tbl_a[0]); push(s + 57, tbl_a[1]);
        pulse_start();
        tick_to(s + 70);
        chk("c5_busy_pre", bus.cfg_busy, 1); chk("c5_addr_pre", bus.lut_addr, 1);
        @(posedge clk_100);
        #3 rst_100 = 1'b0;
        #1;
        chk("c5_req", bus.i2c_req, 0);   chk("c5_busy", bus.cfg_busy, 0);
        chk("c5_done", bus.cfg_done, 0); chk("c5_err", bus.cfg_err, 0);
        chk("c5_addr", bus.lut_addr, 0); chk("c5_data", bus.cfg_data, 0);
        chk("c5_exp_left", exp_q.size(), 0);
        repeat (2) @(negedge clk_100);
        rst_100 = 1'b1;
        req_cnt = 0;
        push(102, tbl_a[0]); push(156, tbl_a[1]); push(210, tbl_a[2]);
        tick_to(262); chk("c5_done_rerun", bus.cfg_done, 1); chk("c5_req_cnt", req_cnt, 3);

        // Case 6: delay word in the table.
        for (int i = 0; i < 3; i++) rom[i] = tbl_b[i];
        do_reset();
`ifdef CFG_DELAY_EN
        // Ack at 152; NEXT/FETCH/LOAD of the delay word, 30 delay cycles, then NEXT/FETCH/LOAD/REQ.
        push(102, tbl_b[0]); push(152 + 3 + 3 * U + 4, tbl_b[2]);
        tick_to(189 + ACK_LAT + 2);
        chk("c6_done", bus.cfg_done, 1); chk("c6_req_cnt", req_cnt, 2);
`else
        push(102, tbl_b[0]); push(156, tbl_b[1]); push(210, tbl_b[2]);
        tick_to(262);
        chk("c6_done", bus.cfg_done, 1); chk("c6_req_cnt", req_cnt, 3);
`endif
        chk("c6_exp_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
